tdm_demux: RTL and testbench
============================

# tdm_demux

Time-division demultiplexer that receives a single-bit serial stream framed by a sync strobe and distributes consecutive slots to N parallel channel registers. It is the receiving end of the team's selector blocks: where a mux merges several sources onto one line, this block recovers them. It sits after the serial link and feeds per-channel consumers. All N channel words update together once per frame.

## Interface
- `N`, default 4: number of channels (slots per frame), N ≥ 2.
- `W`, default 8: bits per slot, W ≥ 2.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `din` input 1: serial data bit, MSB of each slot first.
- `din_valid` input 1: qualifies `din` and `sync`. Cycles with `din_valid`=0 are ignored entirely.
- `sync` input 1: marks bit 0 (MSB) of slot 0; sampled only when `din_valid`=1.
- `ch_data` output N*W: channel words; channel k occupies bits [k*W+W-1 : k*W], and slot k maps to channel k.
- `frame_valid` output 1: one-cycle pulse when `ch_data` has just updated.
- `locked` output 1: high while frame alignment is held.
- `sync_err` output 1: one-cycle pulse on a framing violation.

## Operation
- Reset: one clock, asynchronous active-high reset.
  - While `rst`=1: `ch_data`=0, `frame_valid`=0, `locked`=0, `sync_err`=0, all counters 0, state HUNT, staging register cleared.
- Counters and storage:
  - Bit counter 0..W-1 and slot counter 0..N-1, both clog2-sized.
  - Staging register N*W holds the frame being assembled.
  - `ch_data` is a separate output register.
- State HUNT:
  - A valid beat with `sync`=0 is discarded.
  - A valid beat with `sync`=1 stores `din` as bit W-1 of slot 0, sets bit=1 and slot=0, and moves to RUN.
  - `locked` goes to 1 on the next edge.
- State RUN, on each valid beat:
  - The bit is shifted into the current slot, MSB first.
  - The bit counter increments and wraps at W-1 to 0. The slot counter advances on each bit wrap.
- Frame complete: the beat that fills bit 0 of slot N-1.
  - On the next edge, the full staging contents, including that final bit, are copied to `ch_data` and `frame_valid` pulses.
  - Counters wrap to 0 and the state stays RUN.
- Frame-start check: the first valid beat after frame complete must carry `sync`=1.
  - If `sync`=1: that beat is bit W-1 of the new slot 0 and operation continues normally.
  - If `sync`=0: `sync_err` pulses, the beat is discarded, the state returns to HUNT and `locked` drops.
- Early sync: `sync`=1 on any valid beat in RUN other than a frame-start position.
  - `sync_err` pulses and the partial frame is discarded; `ch_data` is not updated.
  - That beat is treated as bit W-1 of slot 0 of a new frame. The block stays in RUN and `locked` stays 1.
- Gaps: `din_valid` may drop for any number of cycles at any point, mid-slot included. State, counters and staging are held across the gap.
- Output hold: `ch_data` holds its value between frames and across HUNT. It is only overwritten on frame completion.
- Reset mid-frame: everything clears immediately, regardless of clock. The partial frame is lost and no `frame_valid` is produced.

## Timing
- All outputs are registered; nothing combinational runs from input to output.
- Latency: the final bit is sampled on edge t, and `ch_data` and `frame_valid` are valid after edge t+1.
  - With no gaps, one frame is N*W beats, so `frame_valid` repeats every N*W cycles.
- `sync_err` is asserted one cycle after the offending beat, for exactly one cycle.
- `locked` changes one cycle after the beat that causes the state change.
- Frame completion and the next frame's first beat may be consecutive cycles. In that case the `frame_valid` pulse and the new frame's first store happen on the same edge without conflict.

## Test plan
All scenarios use N=4, W=8 unless stated.
- Reset: assert `rst` asynchronously mid-cycle -> all outputs 0 immediately; after release, `locked`=0 until the first sync.
- Clean frame: sync on the first beat; slot bytes 0xA5, 0x3C, 0xFF, 0x01 MSB first, contiguous -> one cycle after beat 32, `frame_valid`=1 and `ch_data`=0x01FF3CA5; `locked`=1.
- Back-to-back frames with gaps:
  - Two frames, `din_valid` toggling 1-0-1-0 throughout -> `ch_data` correct for both frames.
  - `frame_valid` pulses exactly twice, each one cycle after the respective final valid beat.
- Missing frame-start sync: sync absent on beat 33 -> `sync_err` pulses on the next cycle, `locked` drops to 0, `ch_data` retains 0x01FF3CA5.
- Early sync: sync on beat 13 of a frame -> `sync_err` pulses and no `frame_valid` is issued for the partial frame. The next 32 beats complete a frame aligned to beat 13, with the correct `ch_data`.
- Reset mid-frame: `rst` asserted after beat 20 -> no `frame_valid`; `ch_data`=0; after release, the block is in HUNT.

Source files
------------

// File: rtl/tdm_demux_if.sv
// Bus bundle for tdm_demux: serial input side plus the recovered parallel channel words.
// The master modport drives the serial stream; the slave modport is the demultiplexer.
interface tdm_demux_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    logic           din;
    logic           din_valid;
    logic           sync;
    logic [N*W-1:0] ch_data;
    logic           frame_valid;
    logic           locked;
    logic           sync_err;

    modport master (
        output din, din_valid, sync,
        input  ch_data, frame_valid, locked, sync_err
    );

    modport slave (
        input  din, din_valid, sync,
        output ch_data, frame_valid, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: shifts a sync-framed serial stream into N slot words of W bits
// and publishes all channels together, one cycle after the last bit of each frame.
module tdm_demux #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    tdm_demux_if.slave   bus
);
    localparam int unsigned BW = $clog2(W);
    localparam int unsigned SW = $clog2(N);
    localparam logic [BW-1:0] LastBit  = BW'(W - 1);
    localparam logic [SW-1:0] LastSlot = SW'(N - 1);

    typedef enum logic [0:0] {StHunt, StRun} state_e;

    state_e               state_q, state_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]        slot_cnt_q, slot_cnt_d;
    logic [N-1:0][W-1:0]  stage_q, stage_d;
    logic [N*W-1:0]       ch_data_q;
    logic                 done_q, done_d;
    logic                 frame_valid_q;
    logic                 locked_q;
    logic                 sync_err_q, err_d;
    logic                 start_frame;
    logic                 frame_start_pos;

    // In RUN a sync always leaves bit_cnt at 1, so 0/0 only occurs right after a full frame.
    assign frame_start_pos = (bit_cnt_q == '0) && (slot_cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        slot_cnt_d  = slot_cnt_q;
        stage_d     = stage_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        start_frame = 1'b0;

        if (bus.din_valid) begin
            unique case (state_q)
                StHunt: begin
                    start_frame = bus.sync;
                end
                StRun: begin
                    if (frame_start_pos) begin
                        if (bus.sync) begin
                            start_frame = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StHunt;
                        end
                    end else if (bus.sync) begin
                        err_d       = 1'b1;
                        start_frame = 1'b1;
                    end else begin
                        stage_d[slot_cnt_q] = {stage_q[slot_cnt_q][W-2:0], bus.din};
                        if (bit_cnt_q == LastBit) begin
                            bit_cnt_d = '0;
                            if (slot_cnt_q == LastSlot) begin
                                slot_cnt_d = '0;
                                done_d     = 1'b1;
                            end else begin
                                slot_cnt_d = slot_cnt_q + SW'(1);
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end

        // The sync beat is the MSB of slot 0; W-1 further shifts carry it into place.
        if (start_frame) begin
            stage_d    = '0;
            stage_d[0] = {{(W-1){1'b0}}, bus.din};
            bit_cnt_d  = BW'(1);
            slot_cnt_d = '0;
            state_d    = StRun;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StHunt;
            bit_cnt_q     <= '0;
            slot_cnt_q    <= '0;
            stage_q       <= '0;
            ch_data_q     <= '0;
            done_q        <= 1'b0;
            frame_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            slot_cnt_q    <= slot_cnt_d;
            stage_q       <= stage_d;
            done_q        <= done_d;
            // Copies the completed frame from stage_q while a new frame may already be loading.
            if (done_q) begin
                ch_data_q <= stage_q;
            end
            frame_valid_q <= done_q;
            locked_q      <= (state_d == StRun);
            sync_err_q    <= err_d;
        end
    end

    assign bus.ch_data     = ch_data_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.locked      = locked_q;
    assign bus.sync_err    = sync_err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed scenarios plus random streams, all compared each
// cycle against a frame-level model that collects valid beats and packs them per slot.
module tb_tdm_demux;
    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned NW = N * W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    tdm_demux_if #(.N(N), .W(W)) bus ();

    tdm_demux #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: expected outputs after the most recent edge.
    logic          m_fv, m_err, m_lk;
    logic [NW-1:0] m_ch, m_buf, m_done_word;
    logic          m_pend;
    int            m_cnt;

    function automatic void model_reset();
        m_fv = 0; m_err = 0; m_lk = 0; m_ch = '0; m_buf = '0;
        m_done_word = '0; m_pend = 0; m_cnt = 0;
    endfunction

    // Serial beat i of a frame is bit W-1-(i%W) of slot i/W.
    function automatic logic [NW-1:0] pack(input logic [NW-1:0] beats);
        logic [NW-1:0] r;
        r = '0;
        for (int i = 0; i < NW; i++) r[(i / W) * W + (W - 1 - i % W)] = beats[i];
        return r;
    endfunction

    function automatic void model_edge(input logic v, input logic d, input logic s);
        m_fv = m_pend;
        if (m_pend) m_ch = m_done_word;
        m_pend = 0;
        m_err  = 0;
        if (v) begin
            if (!m_lk) begin
                if (s) begin m_lk = 1; m_buf = '0; m_buf[0] = d; m_cnt = 1; end
            end else if (m_cnt == 0 && !s) begin
                m_err = 1; m_lk = 0;
            end else if (s) begin
                m_err = (m_cnt != 0); m_buf = '0; m_buf[0] = d; m_cnt = 1;
            end else begin
                m_buf[m_cnt] = d;
                m_cnt++;
                if (m_cnt == NW) begin
                    m_pend = 1; m_done_word = pack(m_buf); m_cnt = 0;
                end
            end
        end
    endfunction

    function automatic logic [NW+2:0] exp_v();
        return {m_fv, m_err, m_lk, m_ch};
    endfunction

    function automatic logic [NW+2:0] act_v();
        return {bus.frame_valid, bus.sync_err, bus.locked, bus.ch_data};
    endfunction

    task automatic step(input logic v, input logic d, input logic s);
        @(negedge clk);
        bus.din_valid = v; bus.din = d; bus.sync = s;
        @(posedge clk);
        model_edge(v, d, s);
        #1;
    endtask

    task automatic test_reset();
        bus.din_valid = 0; bus.din = 0; bus.sync = 0;
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (act_v() !== '0) begin
            bad++; $display("FAIL reset_state: got %h want 0", act_v());
        end
        @(negedge clk) rst = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, logic'($urandom_range(0, 1)), 1'b0);
            total++;
            if (act_v() !== exp_v() || bus.locked !== 1'b0) begin
                bad++; $display("FAIL reset_hunt beat %0d: got %h want %h", k, act_v(), exp_v());
            end
        end
    endtask

    task automatic test_clean_frame();
        logic [7:0] bytes [4];
        bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
        for (int k = 0; k < 32; k++) begin
            step(1'b1, bytes[k / 8][7 - k % 8], k == 0);
            total++;
            if (act_v() !== exp_v()) begin
                bad++; $display("FAIL clean_frame beat %0d: got %h want %h", k, act_v(), exp_v());
            end
        end
        step(1'b0, 1'b0, 1'b0);
        total++;
        if ({bus.frame_valid, bus.locked, bus.ch_data} !== {2'b11, 32'h01FF3CA5}) begin
            bad++;
            $display("FAIL clean_frame_out: got fv=%b lk=%b ch=%h want fv=1 lk=1 ch=01ff3ca5",
                     bus.frame_valid, bus.locked, bus.ch_data);
        end
        step(1'b0, 1'b0, 1'b0);
        total++;
        if (act_v() !== exp_v() || bus.frame_valid !== 1'b0) begin
            bad++; $display("FAIL clean_frame_pulse: got %h want %h", act_v(), exp_v());
        end
    endtask

    task automatic test_missing_sync();
        step(1'b1, 1'b1, 1'b0);
        total++;
        if ({bus.sync_err, bus.locked, bus.frame_valid, bus.ch_data} !== {3'b100, 32'h01FF3CA5}) begin
            bad++;
            $display("FAIL missing_sync: got err=%b lk=%b fv=%b ch=%h want err=1 lk=0 fv=0 ch=01ff3ca5",
                     bus.sync_err, bus.locked, bus.frame_valid, bus.ch_data);
        end
        step(1'b0, 1'b0, 1'b0);
        total++;
        if (act_v() !== exp_v() || bus.sync_err !== 1'b0) begin
            bad++; $display("FAIL missing_sync_pulse: got %h want %h", act_v(), exp_v());
        end
    endtask

    task automatic test_back_to_back_gaps();
        int fv_seen = 0;
        for (int k = 0; k < 2 * NW; k++) begin
            step(1'b1, logic'($urandom_range(0, 1)), (k % NW) == 0);
            fv_seen += int'(bus.frame_valid);
            total++;
            if (act_v() !== exp_v()) begin
                bad++; $display("FAIL b2b_gaps beat %0d: got %h want %h", k, act_v(), exp_v());
            end
            step(1'b0, 1'b0, 1'b0);
            fv_seen += int'(bus.frame_valid);
            total++;
            if (act_v() !== exp_v()) begin
                bad++; $display("FAIL b2b_gaps gap %0d: got %h want %h", k, act_v(), exp_v());
            end
        end
        step(1'b0, 1'b0, 1'b0);
        fv_seen += int'(bus.frame_valid);
        total++;
        if (fv_seen != 2) begin
            bad++; $display("FAIL b2b_fv_count: got %0d want 2", fv_seen);
        end
    endtask

    task automatic test_early_sync();
        int fv_seen = 0;
        int err_seen = 0;
        // Beat 0 starts a frame, beat 12 is an early sync, then 31 beats finish the new frame.
        for (int k = 0; k < 12 + NW; k++) begin
            step(1'b1, logic'($urandom_range(0, 1)), k == 0 || k == 12);
            fv_seen  += int'(bus.frame_valid);
            err_seen += int'(bus.sync_err);
            total++;
            if (act_v() !== exp_v()) begin
                bad++; $display("FAIL early_sync beat %0d: got %h want %h", k, act_v(), exp_v());
            end
        end
        step(1'b0, 1'b0, 1'b0);
        fv_seen += int'(bus.frame_valid);
        total++;
        if (act_v() !== exp_v() || fv_seen != 1 || err_seen != 1 || bus.frame_valid !== 1'b1) begin
            bad++;
            $display("FAIL early_sync_end: got %h fv=%0d err=%0d want %h fv=1 err=1",
                     act_v(), fv_seen, err_seen, exp_v());
        end
    endtask

    task automatic test_random();
        logic v, s;
        for (int k = 0; k < 1500; k++) begin
            v = ($urandom_range(0, 3) != 0);
            if (!m_lk || m_cnt == 0) s = ($urandom_range(0, 9) != 0);
            else                     s = ($urandom_range(0, 99) == 0);
            step(v, logic'($urandom_range(0, 1)), s);
            total++;
            if (act_v() !== exp_v()) begin
                bad++; $display("FAIL random cyc %0d: got %h want %h", k, act_v(), exp_v());
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int k = 0; k < 20; k++) begin
            step(1'b1, logic'($urandom_range(0, 1)), k == 0);
            total++;
            if (act_v() !== exp_v()) begin
                bad++; $display("FAIL mid_reset beat %0d: got %h want %h", k, act_v(), exp_v());
            end
        end
        @(negedge clk);
        bus.din_valid = 0;
        #2 rst = 1;
        #1;
        model_reset();
        total++;
        if (act_v() !== '0) begin
            bad++; $display("FAIL mid_reset_async: got %h want 0", act_v());
        end
        @(posedge clk);
        #1;
        total++;
        if (act_v() !== '0) begin
            bad++; $display("FAIL mid_reset_held: got %h want 0", act_v());
        end
        @(negedge clk) rst = 0;
        for (int k = 0; k < 4; k++) begin
            step(k != 0, logic'($urandom_range(0, 1)), 1'b0);
            total++;
            if (act_v() !== exp_v() || act_v() !== '0) begin
                bad++; $display("FAIL mid_reset_after %0d: got %h want 0", k, act_v());
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_missing_sync();
        test_back_to_back_gaps();
        test_early_sync();
        test_random();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
